// File: rtl/ann_pkg.sv
// ann_pkg -- shared defaults and state encoding for the k-d tree / query
// load path.
//   DEF_*   : default geometry of the tree, leaf patches and query image
//   state_t : load sequencer phase
package ann_pkg;

   localparam int DEF_DATA_WIDTH = 11;
   localparam int DEF_PATCH_SIZE = 5;
   localparam int DEF_LEAF_SIZE  = 8;
   localparam int DEF_NUM_LEAVES = 64;
   localparam int DEF_NUM_QUERYS = 494;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      NODES   = 3'd1,
      LEAVES  = 3'd2,
      QUERIES = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/patch_assembler.sv
// patch_assembler -- collects PATCH_SIZE words into one packed patch.
// The first word of a patch ends up in the LSBs.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronous clear of word counter and buffer
//   push        : accept data as the next word of the current patch
//   data        : incoming word
//   patch       : buffer contents (complete once the last word was pushed)
//   patch_next  : buffer contents including the word presented on data
//   last        : the next pushed word completes the patch
module patch_assembler #(
   parameter int DATA_WIDTH = 11,
   parameter int PATCH_SIZE = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clear,
   input  logic                             push,
   input  logic [DATA_WIDTH-1:0]            data,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_next,
   output logic                             last
);

   localparam int PW = PATCH_SIZE * DATA_WIDTH;
   localparam int CW = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;

   logic [CW-1:0] count;
   logic [PW-1:0] buffer;

   // New words enter at the top and walk down, so after PATCH_SIZE pushes
   // the first word sits in the LSBs.
   generate
      if (PATCH_SIZE > 1) begin : g_shift
         assign patch_next = {data, buffer[PW-1:DATA_WIDTH]};
      end else begin : g_single
         assign patch_next = data;
      end
   endgenerate

   assign patch = buffer;
   assign last  = (count == CW'(PATCH_SIZE - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         buffer <= '0;
      end else if (clear) begin
         count  <= '0;
         buffer <= '0;
      end else if (push) begin
         buffer <= patch_next;
         count  <= last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/load_sequencer.sv
// load_sequencer -- steers a single word stream into k-d tree node, leaf
// patch and query patch write ports.
//   clk, rst                  : clock, asynchronous active-high reset
//   load_kdtree, load_query   : start pulses (full load / query-only load)
//   in_valid, in_data, in_ready : input word handshake
//   node_we/addr/idx/median   : internal-node write port
//   leaf_we/addr/slot/patch/patch_idx : leaf patch write port
//   query_we/addr/patch       : query patch write port
//   busy, done, err_overrun   : status
module load_sequencer
   import ann_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PATCH_SIZE = DEF_PATCH_SIZE,
   parameter int LEAF_SIZE  = DEF_LEAF_SIZE,
   parameter int NUM_LEAVES = DEF_NUM_LEAVES,
   parameter int NUM_QUERYS = DEF_NUM_QUERYS
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     load_kdtree,
   input  logic                                     load_query,
   input  logic                                     in_valid,
   input  logic [DATA_WIDTH-1:0]                    in_data,
   output logic                                     in_ready,
   output logic                                     node_we,
   output logic [$clog2(NUM_LEAVES-1)-1:0]          node_addr,
   output logic [DATA_WIDTH-1:0]                    node_idx,
   output logic [DATA_WIDTH-1:0]                    node_median,
   output logic                                     leaf_we,
   output logic [$clog2(NUM_LEAVES)-1:0]            leaf_addr,
   output logic [$clog2(LEAF_SIZE)-1:0]             leaf_slot,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0]         leaf_patch,
   output logic [DATA_WIDTH-1:0]                    leaf_patch_idx,
   output logic                                     query_we,
   output logic [$clog2(NUM_QUERYS)-1:0]            query_addr,
   output logic [PATCH_SIZE*DATA_WIDTH-1:0]         query_patch,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     err_overrun
);

   localparam int NODE_AW  = $clog2(NUM_LEAVES - 1);
   localparam int LEAF_AW  = $clog2(NUM_LEAVES);
   localparam int SLOT_W   = $clog2(LEAF_SIZE);
   localparam int QUERY_AW = $clog2(NUM_QUERYS);
   localparam int PW       = PATCH_SIZE * DATA_WIDTH;

   localparam logic [NODE_AW-1:0]  LAST_NODE  = NODE_AW'(NUM_LEAVES - 2);
   localparam logic [LEAF_AW-1:0]  LAST_LEAF  = LEAF_AW'(NUM_LEAVES - 1);
   localparam logic [SLOT_W-1:0]   LAST_SLOT  = SLOT_W'(LEAF_SIZE - 1);
   localparam logic [QUERY_AW-1:0] LAST_QUERY = QUERY_AW'(NUM_QUERYS - 1);

   state_t state, state_next;

   logic                  accept, start;
   logic                  node_half;     // 0: expecting index word, 1: median word
   logic [DATA_WIDTH-1:0] idx_hold;
   logic [NODE_AW-1:0]    node_cnt;
   logic                  idx_phase;     // next leaf word is the patch index
   logic [LEAF_AW-1:0]    leaf_cnt;
   logic [SLOT_W-1:0]     slot_cnt;
   logic [QUERY_AW-1:0]   query_cnt;
   logic                  asm_push, asm_last;
   logic [PW-1:0]         asm_patch, asm_patch_next;

   assign busy     = (state == NODES) || (state == LEAVES) || (state == QUERIES);
   assign done     = (state == DONE);
   assign in_ready = busy;
   assign accept   = in_valid && in_ready;
   assign start    = ((state == IDLE) || (state == DONE)) && (load_kdtree || load_query);

   // The assembler only sees patch data words; leaf index words bypass it.
   assign asm_push = accept && ((state == QUERIES) || ((state == LEAVES) && !idx_phase));

   patch_assembler #(
      .DATA_WIDTH(DATA_WIDTH),
      .PATCH_SIZE(PATCH_SIZE)
   ) u_asm (
      .clk       (clk),
      .rst       (rst),
      .clear     (start),
      .push      (asm_push),
      .data      (in_data),
      .patch     (asm_patch),
      .patch_next(asm_patch_next),
      .last      (asm_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (load_kdtree)     state_next = NODES;
            else if (load_query) state_next = QUERIES;
         end
         NODES:
            if (accept && node_half && (node_cnt == LAST_NODE)) state_next = LEAVES;
         LEAVES:
            if (accept && idx_phase && (slot_cnt == LAST_SLOT) && (leaf_cnt == LAST_LEAF))
               state_next = QUERIES;
         QUERIES:
            if (accept && asm_last && (query_cnt == LAST_QUERY)) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // Item counters and registered write ports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         node_half      <= 1'b0;
         idx_hold       <= '0;
         node_cnt       <= '0;
         idx_phase      <= 1'b0;
         leaf_cnt       <= '0;
         slot_cnt       <= '0;
         query_cnt      <= '0;
         node_we        <= 1'b0;
         node_addr      <= '0;
         node_idx       <= '0;
         node_median    <= '0;
         leaf_we        <= 1'b0;
         leaf_addr      <= '0;
         leaf_slot      <= '0;
         leaf_patch     <= '0;
         leaf_patch_idx <= '0;
         query_we       <= 1'b0;
         query_addr     <= '0;
         query_patch    <= '0;
         err_overrun    <= 1'b0;
      end else begin
         node_we  <= 1'b0;
         leaf_we  <= 1'b0;
         query_we <= 1'b0;

         if (start) begin
            node_half   <= 1'b0;
            idx_hold    <= '0;
            node_cnt    <= '0;
            idx_phase   <= 1'b0;
            leaf_cnt    <= '0;
            slot_cnt    <= '0;
            query_cnt   <= '0;
            err_overrun <= 1'b0;
         end else begin
            if (!busy && in_valid) err_overrun <= 1'b1;

            if (accept && (state == NODES)) begin
               if (!node_half) begin
                  idx_hold  <= in_data;
                  node_half <= 1'b1;
               end else begin
                  node_half   <= 1'b0;
                  node_cnt    <= node_cnt + 1'b1;
                  node_we     <= 1'b1;
                  node_addr   <= node_cnt;
                  node_idx    <= idx_hold;
                  node_median <= in_data;
               end
            end

            if (accept && (state == LEAVES)) begin
               if (idx_phase) begin
                  idx_phase      <= 1'b0;
                  leaf_we        <= 1'b1;
                  leaf_addr      <= leaf_cnt;
                  leaf_slot      <= slot_cnt;
                  leaf_patch     <= asm_patch;
                  leaf_patch_idx <= in_data;
                  if (slot_cnt == LAST_SLOT) begin
                     slot_cnt <= '0;
                     leaf_cnt <= leaf_cnt + 1'b1;
                  end else begin
                     slot_cnt <= slot_cnt + 1'b1;
                  end
               end else if (asm_last) begin
                  idx_phase <= 1'b1;
               end
            end

            if (accept && (state == QUERIES) && asm_last) begin
               query_cnt   <= query_cnt + 1'b1;
               query_we    <= 1'b1;
               query_addr  <= query_cnt;
               query_patch <= asm_patch_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_load_sequencer.sv
// tb_load_sequencer -- directed bench for load_sequencer with default
// parameters: full load, query-only load with bubbles, overrun flag,
// mid-load reset and start priority.
module tb_load_sequencer;

   localparam int DW = 11;
   localparam int PW = 5 * DW;

   logic          clk = 1'b0;
   logic          rst, load_kdtree, load_query, in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready, node_we, leaf_we, query_we, busy, done, err_overrun;
   logic [5:0]    node_addr, leaf_addr;
   logic [2:0]    leaf_slot;
   logic [8:0]    query_addr;
   logic [DW-1:0] node_idx, node_median, leaf_patch_idx;
   logic [PW-1:0] leaf_patch, query_patch;

   int tests = 0;
   int failed = 0;

   int n_node = 0;
   int n_leaf = 0;
   int n_query = 0;
   int q_expect = 0;
   int q_order_err = 0;
   int s_node, s_leaf, s_query;

   load_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .load_kdtree   (load_kdtree),
      .load_query    (load_query),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .node_we       (node_we),
      .node_addr     (node_addr),
      .node_idx      (node_idx),
      .node_median   (node_median),
      .leaf_we       (leaf_we),
      .leaf_addr     (leaf_addr),
      .leaf_slot     (leaf_slot),
      .leaf_patch    (leaf_patch),
      .leaf_patch_idx(leaf_patch_idx),
      .query_we      (query_we),
      .query_addr    (query_addr),
      .query_patch   (query_patch),
      .busy          (busy),
      .done          (done),
      .err_overrun   (err_overrun)
   );

   always #5 clk = ~clk;

   // Strobe tally and query address ordering, sampled mid-cycle.
   always @(negedge clk) begin
      if (node_we) n_node++;
      if (leaf_we) n_leaf++;
      if (query_we) begin
         if (int'(query_addr) != q_expect) q_order_err++;
         q_expect = (q_expect == 493) ? 0 : q_expect + 1;
         n_query++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d);
      in_valid = 1'b1;
      in_data  = DW'(d);
      step();
   endtask

   initial begin
      rst = 1'b1; load_kdtree = 1'b0; load_query = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) step();
      check("rst_in_ready", 64'(in_ready), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_err", 64'(err_overrun), 0);
      check("rst_strobes", 64'({node_we, leaf_we, query_we}), 0);
      rst = 1'b0;
      step();

      // Full load
      load_kdtree = 1'b1; step(); load_kdtree = 1'b0;
      check("start_busy", 64'(busy), 1);
      check("start_in_ready", 64'(in_ready), 1);

      send(3); send(512);
      check("node0_we", 64'(node_we), 1);
      check("node0_addr", 64'(node_addr), 0);
      check("node0_idx", 64'(node_idx), 3);
      check("node0_median", 64'(node_median), 512);
      for (int n = 1; n < 63; n++) begin
         send(n); send(n + 500);
      end
      check("node62_addr", 64'(node_addr), 62);
      check("node62_median", 64'(node_median), 562);

      for (int p = 0; p < 512; p++) begin
         for (int k = 0; k < 5; k++) send((p * 5 + k + 1) % 2048);
         send((p + 17) % 2048);
         if (p == 0) begin
            check("leaf0_we", 64'(leaf_we), 1);
            check("leaf0_addr", 64'(leaf_addr), 0);
            check("leaf0_slot", 64'(leaf_slot), 0);
            check("leaf0_patch", 64'(leaf_patch), 64'({11'd5, 11'd4, 11'd3, 11'd2, 11'd1}));
            check("leaf0_idx", 64'(leaf_patch_idx), 17);
         end
         if (p == 511) begin
            check("leaf511_addr", 64'(leaf_addr), 63);
            check("leaf511_slot", 64'(leaf_slot), 7);
            check("leaf511_patch", 64'(leaf_patch),
                  64'({11'd512, 11'd511, 11'd510, 11'd509, 11'd508}));
            check("leaf511_idx", 64'(leaf_patch_idx), 528);
         end
      end

      for (int q = 0; q < 494; q++)
         for (int k = 0; k < 5; k++) send((q * 3 + k) % 2048);
      check("qlast_we", 64'(query_we), 1);
      check("qlast_addr", 64'(query_addr), 493);
      check("qlast_done", 64'(done), 1);
      check("qlast_in_ready", 64'(in_ready), 0);
      check("qlast_busy", 64'(busy), 0);
      check("qlast_patch", 64'(query_patch),
            64'({11'd1483, 11'd1482, 11'd1481, 11'd1480, 11'd1479}));
      in_valid = 1'b0;
      step();
      check("full_node_count", 64'(n_node), 63);
      check("full_leaf_count", 64'(n_leaf), 512);
      check("full_query_count", 64'(n_query), 494);
      check("full_query_order", 64'(q_order_err), 0);
      check("full_err", 64'(err_overrun), 0);

      // Query-only load with input bubbles
      s_node = n_node; s_leaf = n_leaf; s_query = n_query;
      load_query = 1'b1; step(); load_query = 1'b0;
      check("qonly_busy", 64'(busy), 1);
      for (int i = 0; i < 2470; i++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) step();
         send(i % 2048);
      end
      in_valid = 1'b0;
      step();
      check("qonly_done", 64'(done), 1);
      check("qonly_node_count", 64'(n_node - s_node), 0);
      check("qonly_leaf_count", 64'(n_leaf - s_leaf), 0);
      check("qonly_query_count", 64'(n_query - s_query), 494);
      check("qonly_query_order", 64'(q_order_err), 0);
      check("qonly_patch", 64'(query_patch),
            64'({11'd421, 11'd420, 11'd419, 11'd418, 11'd417}));

      // Overrun in DONE
      s_node = n_node; s_leaf = n_leaf; s_query = n_query;
      in_valid = 1'b1; in_data = 11'd9; step();
      in_valid = 1'b0; step();
      check("overrun_set", 64'(err_overrun), 1);
      check("overrun_no_strobe", 64'((n_node - s_node) + (n_leaf - s_leaf) + (n_query - s_query)), 0);
      load_kdtree = 1'b1; step(); load_kdtree = 1'b0;
      check("overrun_cleared", 64'(err_overrun), 0);
      check("restart_busy", 64'(busy), 1);

      // Reset in the middle of LEAVES
      for (int i = 0; i < 126; i++) send(i);
      for (int i = 0; i < 10; i++) send(i + 1);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 64'(in_ready), 0);
      check("midrst_busy", 64'(busy), 0);
      check("midrst_strobes", 64'({node_we, leaf_we, query_we}), 0);
      check("midrst_leaf_addr", 64'(leaf_addr), 0);
      s_leaf = n_leaf;
      step(); step();
      rst = 1'b0;
      check("midrst_no_leaf", 64'(n_leaf - s_leaf), 0);

      // Both starts in one cycle go to NODES; node numbering restarts at 0
      load_kdtree = 1'b1; load_query = 1'b1; step();
      load_kdtree = 1'b0; load_query = 1'b0;
      check("both_busy", 64'(busy), 1);
      send(7); send(9);
      check("both_node_we", 64'(node_we), 1);
      check("both_node_addr", 64'(node_addr), 0);
      check("both_node_idx", 64'(node_idx), 7);
      check("both_node_median", 64'(node_median), 9);
      in_valid = 1'b0;
      load_query = 1'b1; step(); load_query = 1'b0;
      send(4); send(6);
      check("ignored_start_addr", 64'(node_addr), 1);
      check("ignored_start_idx", 64'(node_idx), 4);
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  DATA_WIDTH  11  bits per input word
  PATCH_SIZE  5  data words per patch
  LEAF_SIZE  8  patches per leaf
  NUM_LEAVES  64  leaves; internal nodes = NUM_LEAVES-1
  NUM_QUERYS  494  query patches (26x19 image)
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock
  rst  in  1  asynchronous, active-high reset
  load_kdtree  in  1  pulse: start full load (nodes, leaves, queries)
  load_query  in  1  pulse: start query-only load
  in_valid  in  1  input word valid
  in_data  in  DATA_WIDTH  input word
  in_ready  out  1  word accepted when in_valid and in_ready
  node_we  out  1  internal-node write strobe
  node_addr  out  clog2(NUM_LEAVES-1)  node number
  node_idx  out  DATA_WIDTH  split dimension
  node_median  out  DATA_WIDTH  split median
  leaf_we  out  1  leaf-patch write strobe
  leaf_addr  out  clog2(NUM_LEAVES)  leaf number
  leaf_slot  out  clog2(LEAF_SIZE)  patch slot within leaf
  leaf_patch  out  PATCH_SIZE*DATA_WIDTH  packed patch
  leaf_patch_idx  out  DATA_WIDTH  original-image patch index
  query_we  out  1  query write strobe
  query_addr  out  clog2(NUM_QUERYS)  query number
  query_patch  out  PATCH_SIZE*DATA_WIDTH  packed query
  busy  out  1  load in progress
  done  out  1  load complete, held until next start
  err_overrun  out  1  sticky: in_valid seen while not loading

Function
REQ-003 States: IDLE, NODES, LEAVES, QUERIES, DONE.
REQ-004 IDLE/DONE: load_kdtree -> NODES; load_query -> QUERIES; both same cycle -> NODES.
REQ-005 Starts in NODES/LEAVES/QUERIES ignored.
REQ-006 NODES: 2*(NUM_LEAVES-1) words, per node index then median, nodes ascending; after last word -> LEAVES.
REQ-007 LEAVES: per patch PATCH_SIZE data words then 1 index word; LEAF_SIZE patches per leaf, leaves ascending; after NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1) words -> QUERIES.
REQ-008 QUERIES: NUM_QUERYS*PATCH_SIZE words; after last word -> DONE.
REQ-009 Packing: k-th word of a patch at bits [k*DATA_WIDTH +: DATA_WIDTH] (first word LSBs).
REQ-010 in_ready = 1 exactly in NODES, LEAVES, QUERIES; counters advance only on accepted words; in_valid bubbles of any length allowed.
REQ-011 Write strobes single-cycle, registered, asserted cycle after item's final word accepted; addr/data valid same cycle; at most one strobe per cycle.
REQ-012 State transition on final-word acceptance cycle; done=1 from next cycle; first word of next phase accepted back-to-back.
REQ-013 busy = state in {NODES, LEAVES, QUERIES}; done = state DONE.
REQ-014 err_overrun set when in_valid=1 in IDLE or DONE; cleared only by accepted start or rst.
REQ-015 Start clears all counters and patch buffer.

Reset
REQ-016 rst asynchronously forces IDLE; all counters, buffers zero; every output 0 including in_ready, strobes, busy, done, err_overrun.
REQ-017 rst mid-load abandons load; no strobe issued after rst asserts.

Structure
REQ-018 Shared package ann_pkg holds default DATA_WIDTH/PATCH_SIZE/LEAF_SIZE/NUM_LEAVES/NUM_QUERYS and state enum.
REQ-019 One sub-module patch_assembler: word counter plus shift buffer producing packed patch and last-word flag, reused for leaves and queries.

Verification
REQ-020 Full load, default params, 5668 contiguous words; node 0 words 3, 512 -> next cycle node_we=1, node_addr=0, node_idx=3, node_median=512.
REQ-021 Leaf 0 words 1,2,3,4,5,17 -> leaf_we=1, leaf_addr=0, leaf_slot=0, leaf_patch={5,4,3,2,1}, leaf_patch_idx=17; 512th patch -> leaf_addr=63, leaf_slot=7.
REQ-022 Final query word accepted -> query_we=1, query_addr=493, done=1 same cycle, in_ready=0.
REQ-023 load_query from DONE, 2470 words with random in_valid bubbles -> no node_we/leaf_we, 494 query_we pulses, addresses 0..493 in order.
REQ-024 rst asserted mid-LEAVES -> outputs 0 immediately; subsequent load_kdtree restarts at node_addr 0.
REQ-025 in_valid=1 in DONE -> err_overrun=1, no strobes; load_kdtree clears it; load_kdtree+load_query same cycle -> NODES.
